// File: rtl/button_control.sv
// Front-panel pushbutton decoder: synchronises and debounces an active-low pin, then
// classifies each gesture as a short, double or long press with one-clock event pulses.
module button_control #(
    parameter int unsigned clock_speed = 12_500_000,
    parameter int unsigned debounce_ms = 20,
    parameter int unsigned double_ms   = 300,
    parameter int unsigned long_ms     = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_n,
    output logic pressed,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic hold
);

    localparam int unsigned ms_cycles       = clock_speed / 1000;
    localparam logic [23:0] debounce_cycles = 24'(ms_cycles * debounce_ms);
    localparam logic [23:0] double_cycles   = 24'(ms_cycles * double_ms);
    localparam logic [23:0] long_cycles     = 24'(ms_cycles * long_ms);
    localparam logic [23:0] debounce_last   = debounce_cycles - 24'd1;
    localparam logic [23:0] double_last     = double_cycles - 24'd1;
    localparam logic [23:0] long_last       = long_cycles - 24'd1;

    typedef enum logic [2:0] {
        StIdle,
        StDown1,
        StUp1,
        StDown2,
        StHeld
    } state_t;

    logic        sync_1, sync_2;
    logic [23:0] db_cnt_q, db_cnt_d;
    logic        toggle;
    logic [23:0] timer_q, timer_d;
    state_t      state_q, state_d;
    logic        short_d, double_d, long_d, hold_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= button_n;
            sync_2 <= sync_1;
        end
    end

    always_comb begin
        db_cnt_d = '0;
        toggle   = 1'b0;
        if (~sync_2 != pressed) begin
            if (db_cnt_q == debounce_last) begin
                toggle = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + 24'd1;
            end
        end
    end

    // The timer restarts on each debounced edge, so it already reads 1 on the first cycle of
    // the state that edge leads to; terminal counts then land exactly *_cycles after the edge.
    always_comb begin
        timer_d = timer_q;
        if (toggle) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 24'd1;
        end
    end

    // A debounced edge arriving on the terminal-count cycle suppresses the timed event.
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        hold_d   = hold;
        unique case (state_q)
            StIdle: begin
                if (pressed) state_d = StDown1;
            end
            StDown1: begin
                if (!pressed) begin
                    state_d = StUp1;
                end else if (!toggle && timer_q >= long_last) begin
                    long_d  = 1'b1;
                    hold_d  = 1'b1;
                    state_d = StHeld;
                end
            end
            StUp1: begin
                if (pressed) begin
                    state_d = StDown2;
                end else if (!toggle && timer_q >= double_last) begin
                    short_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StDown2: begin
                if (!pressed) begin
                    double_d = 1'b1;
                    state_d  = StIdle;
                end else if (!toggle && timer_q >= long_last) begin
                    long_d  = 1'b1;
                    hold_d  = 1'b1;
                    state_d = StHeld;
                end
            end
            StHeld: begin
                if (!pressed) begin
                    hold_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt_q     <= '0;
            pressed      <= 1'b0;
            timer_q      <= '0;
            state_q      <= StIdle;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            hold         <= 1'b0;
        end else begin
            db_cnt_q     <= db_cnt_d;
            pressed      <= pressed ^ toggle;
            timer_q      <= timer_d;
            state_q      <= state_d;
            short_press  <= short_d;
            double_press <= double_d;
            long_press   <= long_d;
            hold         <= hold_d;
        end
    end

endmodule

// File: tb/tb_button_control.sv
// Scoreboard bench for button_control: each stimulus step queues the events it should cause,
// and a negedge monitor pops and compares every observed event against that queue.
module tb_button_control;

    logic clock = 1'b0;
    logic reset;
    logic button_n;
    logic pressed, short_press, double_press, long_press, hold;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef enum int {EvRise, EvFall, EvShort, EvDouble, EvLong, EvHoldFall} ev_t;
    typedef struct {
        ev_t kind;
        int  cyc;
    } exp_t;
    exp_t exp_q[$];

    button_control #(
        .clock_speed(1000),
        .debounce_ms(4),
        .double_ms  (20),
        .long_ms    (50)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .button_n    (button_n),
        .pressed     (pressed),
        .short_press (short_press),
        .double_press(double_press),
        .long_press  (long_press),
        .hold        (hold)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic expect_ev(input ev_t k, input int c);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_t k);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk($sformatf("spurious %s", k.name()), int'(k), -1);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("kind of %s", e.kind.name()), int'(k), int'(e.kind));
            chk($sformatf("cycle of %s", e.kind.name()), cyc, e.cyc);
        end
    endtask

    logic prev_pressed = 1'b0;
    logic prev_hold    = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            if (pressed != prev_pressed) observe(pressed ? EvRise : EvFall);
            if (short_press) observe(EvShort);
            if (double_press) observe(EvDouble);
            if (long_press) begin
                observe(EvLong);
                chk("hold with long_press", int'(hold), 1);
            end
            if (prev_hold && !hold) observe(EvHoldFall);
        end
        prev_pressed = pressed;
        prev_hold    = hold;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pressed"}, int'(pressed), 0);
        chk({tag, " short_press"}, int'(short_press), 0);
        chk({tag, " double_press"}, int'(double_press), 0);
        chk({tag, " long_press"}, int'(long_press), 0);
        chk({tag, " hold"}, int'(hold), 0);
    endtask

    task automatic pulse_reset(input logic pin_during);
        reset = 1'b1;
        #1;
        chk_all_zero("mid-gesture reset");
        button_n = pin_during;
        step(3);
        reset = 1'b0;
    endtask

    initial begin
        int e0;
        int r;
        button_n = 1'b1;
        reset    = 1'b1;
        step(3);
        chk_all_zero("reset");
        reset = 1'b0;
        step(5);

        // Bounce rejection, then a clean 10-clock press that ends as a short press.
        repeat (3) begin
            button_n = 1'b0;
            step(3);
            button_n = 1'b1;
            step(5);
        end
        step(10);
        chk("pressed after glitches", int'(pressed), 0);
        chk("events after glitches", exp_q.size(), 0);
        e0 = cyc;
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 6);
        step(10);
        button_n = 1'b1;
        expect_ev(EvFall, e0 + 16);
        expect_ev(EvShort, e0 + 36);
        step(45);
        chk("pending after debounce", exp_q.size(), 0);

        // Short press.
        e0 = cyc;
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 6);
        step(15);
        button_n = 1'b1;
        expect_ev(EvFall, e0 + 21);
        expect_ev(EvShort, e0 + 41);
        step(45);
        chk("pending after short", exp_q.size(), 0);

        // Double press.
        e0 = cyc;
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 6);
        step(10);
        button_n = 1'b1;
        expect_ev(EvFall, e0 + 16);
        step(8);
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 24);
        step(10);
        button_n = 1'b1;
        expect_ev(EvFall, e0 + 34);
        expect_ev(EvDouble, e0 + 35);
        step(40);
        chk("pending after double", exp_q.size(), 0);

        // Long press.
        e0 = cyc;
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 6);
        expect_ev(EvLong, e0 + 56);
        step(80);
        button_n = 1'b1;
        expect_ev(EvFall, e0 + 86);
        expect_ev(EvHoldFall, e0 + 87);
        step(30);
        chk("pending after long", exp_q.size(), 0);

        // Second press of a double held long: long only.
        e0 = cyc;
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 6);
        step(10);
        button_n = 1'b1;
        expect_ev(EvFall, e0 + 16);
        step(8);
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 24);
        expect_ev(EvLong, e0 + 74);
        step(60);
        button_n = 1'b1;
        expect_ev(EvFall, e0 + 84);
        expect_ev(EvHoldFall, e0 + 85);
        step(30);
        chk("pending after double-long", exp_q.size(), 0);

        // Second rise coincides with the double-window terminal count: edge wins.
        e0 = cyc;
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 6);
        step(10);
        button_n = 1'b1;
        expect_ev(EvFall, e0 + 16);
        step(20);
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 36);
        step(10);
        button_n = 1'b1;
        expect_ev(EvFall, e0 + 46);
        expect_ev(EvDouble, e0 + 47);
        step(40);
        chk("pending after coincident edge", exp_q.size(), 0);

        // One clock later the window has closed: short, then a fresh gesture.
        e0 = cyc;
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 6);
        step(10);
        button_n = 1'b1;
        expect_ev(EvFall, e0 + 16);
        expect_ev(EvShort, e0 + 36);
        step(21);
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 37);
        step(10);
        button_n = 1'b1;
        expect_ev(EvFall, e0 + 47);
        expect_ev(EvShort, e0 + 67);
        step(45);
        chk("pending after late second press", exp_q.size(), 0);

        // Reset during DOWN1, pin released meanwhile.
        e0 = cyc;
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 6);
        step(15);
        pulse_reset(1'b1);
        step(40);
        chk("pending after reset in DOWN1", exp_q.size(), 0);

        // Reset during UP1.
        e0 = cyc;
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 6);
        step(10);
        button_n = 1'b1;
        expect_ev(EvFall, e0 + 16);
        step(10);
        pulse_reset(1'b1);
        step(40);
        chk("pending after reset in UP1", exp_q.size(), 0);

        // Reset during HELD with the pin still low: a new press appears after debounce.
        e0 = cyc;
        button_n = 1'b0;
        expect_ev(EvRise, e0 + 6);
        expect_ev(EvLong, e0 + 56);
        step(65);
        pulse_reset(1'b0);
        r = cyc;
        expect_ev(EvRise, r + 6);
        step(10);
        button_n = 1'b1;
        expect_ev(EvFall, r + 16);
        expect_ev(EvShort, r + 36);
        step(45);
        chk("pending after reset in HELD", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_control.md
# button_control

Front-panel pushbutton decoder: the input-side companion to the LED driver. It synchronises and debounces one raw active-low button pin and classifies each gesture as a short press, double press or long press. Each gesture is reported as a one-clock event pulse, alongside a debounced level and a hold level. It sits beside the LED driver in the top level, and its events feed the mode and status logic that in turn drive `on`/`slow_flash`/`fast_flash`.

## Interface
Parameters:
- `clock_speed`, 12_500_000: clock frequency in Hz.
- `debounce_ms`, 20: required stable time before a level change is accepted.
- `double_ms`, 300: window after a release in which a second press makes a double press.
- `long_ms`, 1000: hold time that makes a long press.
- Derived: `ms_cycles = clock_speed/1000`; `debounce_cycles`, `double_cycles` and `long_cycles` are each `ms_cycles ×` the matching `_ms` value. Each must be ≥1 and <2^24. All timers are 24-bit.

Ports (reset is asynchronous and active-high):
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `button_n`  in  1  raw pin, asynchronous to `clock`, low = pressed.
- `pressed`  out  1  debounced level, 1 = pressed.
- `short_press`  out  1  one-clock pulse.
- `double_press`  out  1  one-clock pulse.
- `long_press`  out  1  one-clock pulse.
- `hold`  out  1  high from the `long_press` pulse until debounced release.

## Operation
- Synchroniser: two flops on `button_n`, both reset to 1 (released).
- Debouncer:
  - The 24-bit counter increments each clock while the synchronised level differs from `pressed`, and clears when they match.
  - When the count reaches `debounce_cycles`, `pressed` toggles and the counter clears.
  - Glitches shorter than `debounce_cycles` never reach `pressed`.
- Gesture FSM, clocked by the debounced level; the 24-bit `timer` clears on every state change:
  - IDLE: `pressed` rises → DOWN1.
  - DOWN1: `timer` increments.
    - `timer == long_cycles-1` while still pressed → pulse `long_press`, set `hold`, go to HELD.
    - `pressed` falls first → UP1.
  - UP1: `timer` increments.
    - `pressed` rises → DOWN2.
    - `timer == double_cycles-1` → pulse `short_press`, go to IDLE.
  - DOWN2: `timer` increments.
    - `pressed` falls → pulse `double_press`, go to IDLE.
    - `timer == long_cycles-1` → pulse `long_press`, set `hold`, go to HELD. No double is reported in this case.
  - HELD: `pressed` falls → clear `hold`, go to IDLE. No further events are reported.
- If a timer terminal count and an edge of `pressed` fall in the same cycle, the edge wins.
- At most one event pulse is high in any cycle. Event pulses are registered.
- A third press inside a double window is not special. After `double_press` the FSM is in IDLE, so the next press starts a new gesture.

## Timing
- Reset values: `pressed`=0, `short_press`=`double_press`=`long_press`=0, `hold`=0. FSM is in IDLE, the counter and `timer` are 0, and the synchroniser holds 1.
- Reset asserted mid-gesture aborts the gesture silently. After deassert, a button that is still held shows up as a new press after the debounce time.
- `pressed` follows a clean pin edge after `debounce_cycles+2` clocks (+1 for asynchronous sampling).
- `long_press` and the rise of `hold` occur `long_cycles` clocks after `pressed` rises, in DOWN1 or DOWN2.
- `short_press` occurs `double_cycles` clocks after `pressed` falls.
- `double_press` occurs 1 clock after the second fall of `pressed`.
- `hold` falls 1 clock after `pressed` falls.
- Every event pulse is exactly 1 clock wide.

## Test plan
Bench parameters: `clock_speed`=1000, `debounce_ms`=4, `double_ms`=20, `long_ms`=50 (1 cycle per ms).
- Bounce rejection: drive 3-clock low glitches on `button_n` → `pressed` stays 0 and no pulses occur. Then hold the pin low for 10 clocks → `pressed` rises 6±1 clocks after the pin edge.
- Short press: hold low for 15 clocks, then release → exactly one `short_press`, 20 clocks after `pressed` falls. No other pulses.
- Double press: 10 clocks low, 8 high, 10 low, then release → one `double_press`, 1 clock after the second fall of `pressed`. No `short_press`.
- Long press: hold low for 80 clocks → `long_press` 50 clocks after `pressed` rises, `hold` high until 1 clock after `pressed` falls, and nothing more. Repeat with the second press of a double held for 60 clocks → `long_press` only.
- Simultaneous events: in UP1, make `pressed` rise on the cycle where `timer`=19 → DOWN2 is entered and no `short_press` is issued.
- Reset mid-gesture: assert `reset` during DOWN1, UP1 and HELD → all outputs are 0 immediately and no event follows. With the pin still held low, `pressed` rises 6±1 clocks after deassert.
